// File: rtl/alarm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alarm_pkg
//  Purpose  : Shared types, encodings and time-of-day helpers for alarm_bank
//  Revision : 1.0  initial release
// ============================================================================
package alarm_pkg;

  // Ring state machine encoding
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } ring_state_e;

  // Edit field selector encodings
  localparam logic [1:0] FIELD_SLOT = 2'd0;
  localparam logic [1:0] FIELD_HOUR = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_SEC  = 2'd3;

  // Time-of-day limits
  localparam logic [6:0] HOURS_PER_DAY = 7'd24;
  localparam logic [6:0] MINS_PER_HOUR = 7'd60;
  localparam logic [6:0] SECS_PER_MIN  = 7'd60;

  // Packed hour/minute/second triple
  typedef struct packed {
    logic [6:0] hour;
    logic [6:0] min;
    logic [6:0] sec;
  } tod_t;

  // Increment with wrap to zero at lim
  function automatic logic [6:0] wrap_inc(input logic [6:0] v, input logic [6:0] lim);
    return (v >= lim - 7'd1) ? 7'd0 : v + 7'd1;
  endfunction

  // Decrement with wrap from zero to lim-1
  function automatic logic [6:0] wrap_dec(input logic [6:0] v, input logic [6:0] lim);
    return (v == 7'd0) ? lim - 7'd1 : v - 7'd1;
  endfunction

  // Add up to 59 minutes to a time of day, carrying into the hour with day wrap
  function automatic tod_t add_minutes(input tod_t t, input logic [6:0] m);
    tod_t       r;
    logic [6:0] s;
    r = t;
    s = t.min + m;
    if (s >= MINS_PER_HOUR) begin
      r.min  = s - MINS_PER_HOUR;
      r.hour = wrap_inc(t.hour, HOURS_PER_DAY);
    end else begin
      r.min  = s;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alarm_bank_tone_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tone_gen
//  Purpose  : Piezo square-wave driver; half-period of TONE_DIV clocks,
//             restarts from a low level every time EN rises
//  Revision : 1.0  initial release
// ============================================================================
module tone_gen #(
  parameter int TONE_DIV = 500
) (
  input  logic CLK,
  input  logic RESETN,
  input  logic EN,
  output logic PIEZO
);

  localparam int              CNT_W    = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TONE_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tone_q, tone_d;

  // Divider: hold cleared while disabled, toggle the tone at the end of each half-period
  always_comb begin
    cnt_d  = cnt_q;
    tone_d = tone_q;
    if (!EN) begin
      cnt_d  = '0;
      tone_d = 1'b0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      tone_d = ~tone_q;
    end else begin
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  // Divider registers
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
    end
  end

  // Gate with EN so the buzzer goes quiet in the same cycle the ring ends
  assign PIEZO = tone_q & EN;

endmodule
`default_nettype wire

// File: rtl/alarm_bank.sv
`default_nettype none
// ============================================================================
//  Module   : alarm_bank
//  Purpose  : N_ALARM alarm slots with field-wise editing, ring/snooze/dismiss
//             state machine and piezo driver
//  Revision : 1.0  initial release
// ============================================================================
module alarm_bank
  import alarm_pkg::*;
#(
  parameter int N_ALARM      = 4,
  parameter int EDIT_STATE   = 2,
  parameter int CLOCK_STATE  = 0,
  parameter int TONE_DIV     = 500,
  parameter int SNOOZE_MIN   = 5,
  parameter int RING_TIMEOUT = 60
) (
  input  logic               CLK,
  input  logic               RESETN,
  input  logic [2:0]         STATE,
  input  logic               UP,
  input  logic               DOWN,
  input  logic               SHIFT,
  input  logic               OK,
  input  logic               SEC_TICK,
  input  logic [6:0]         HOUR,
  input  logic [6:0]         MIN,
  input  logic [6:0]         SEC,
  output logic [6:0]         ARM_HOUR,
  output logic [6:0]         ARM_MIN,
  output logic [6:0]         ARM_SEC,
  output logic [2:0]         SEL_ALARM,
  output logic [1:0]         FIELD_SEL,
  output logic [N_ALARM-1:0] ARM_EN,
  output logic               RINGING,
  output logic [2:0]         RING_ID,
  output logic               PIEZO
);

  localparam logic [2:0] EDIT_CODE   = 3'(EDIT_STATE);
  localparam logic [2:0] CLOCK_CODE  = 3'(CLOCK_STATE);
  localparam logic [2:0] SEL_LAST    = 3'(N_ALARM - 1);
  localparam logic [6:0] SNOOZE_LEN  = 7'(SNOOZE_MIN);
  localparam logic [7:0] TIMEOUT_CNT = 8'(RING_TIMEOUT);

  tod_t               slot_q [N_ALARM];
  tod_t               slot_d [N_ALARM];
  logic [N_ALARM-1:0] en_q, en_d;
  tod_t               work_q, work_d;
  logic [2:0]         sel_q, sel_d;
  logic [1:0]         field_q, field_d;

  ring_state_e        state_q, state_d;
  logic [2:0]         ring_id_q, ring_id_d;
  tod_t               snooze_q, snooze_d;
  logic [7:0]         tmo_q, tmo_d;

  logic               in_edit, in_clock;
  tod_t               now_tod, cur_slot, step_slot;
  logic [2:0]         sel_step;
  logic [N_ALARM-1:0] hit_vec;
  logic               any_hit;
  logic [2:0]         hit_id;

  assign in_edit  = (STATE == EDIT_CODE);
  assign in_clock = (STATE == CLOCK_CODE);
  assign now_tod  = {HOUR, MIN, SEC};

  generate
    for (genvar g = 0; g < N_ALARM; g++) begin : g_match
      assign hit_vec[g] = en_q[g] && (slot_q[g] == now_tod);
    end
  endgenerate

  assign any_hit = |hit_vec;

  // Priority encode the hit vector; scanning downward leaves the lowest index
  always_comb begin
    hit_id = '0;
    for (int i = N_ALARM - 1; i >= 0; i--) begin
      if (hit_vec[i]) hit_id = 3'(i);
    end
  end

  // Selected slot and its UP/DOWN neighbour, used for display and reload
  always_comb begin
    sel_step  = '0;
    cur_slot  = '0;
    step_slot = '0;
    if (UP) sel_step = (sel_q == SEL_LAST) ? 3'd0 : sel_q + 3'd1;
    else    sel_step = (sel_q == 3'd0) ? SEL_LAST : sel_q - 3'd1;
    for (int i = 0; i < N_ALARM; i++) begin
      if (sel_q == 3'(i))    cur_slot  = slot_q[i];
      if (sel_step == 3'(i)) step_slot = slot_q[i];
    end
  end

  // Editing: outside edit mode the working copy shadows the selected slot,
  // so it is already loaded on the first edit-mode cycle
  always_comb begin
    slot_d  = slot_q;
    en_d    = en_q;
    work_d  = work_q;
    sel_d   = sel_q;
    field_d = field_q;
    if (!in_edit) begin
      work_d = cur_slot;
    end else begin
      if (SHIFT) field_d = field_q + 2'd1;
      if (UP ^ DOWN) begin
        case (field_q)
          FIELD_SLOT: begin
            sel_d  = sel_step;
            work_d = step_slot;
          end
          FIELD_HOUR: work_d.hour = UP ? wrap_inc(work_q.hour, HOURS_PER_DAY)
                                       : wrap_dec(work_q.hour, HOURS_PER_DAY);
          FIELD_MIN:  work_d.min  = UP ? wrap_inc(work_q.min, MINS_PER_HOUR)
                                       : wrap_dec(work_q.min, MINS_PER_HOUR);
          FIELD_SEC:  work_d.sec  = UP ? wrap_inc(work_q.sec, SECS_PER_MIN)
                                       : wrap_dec(work_q.sec, SECS_PER_MIN);
          default:    work_d = work_q;
        endcase
      end
      if (OK) begin
        for (int i = 0; i < N_ALARM; i++) begin
          if (sel_q == 3'(i)) begin
            if (field_q == FIELD_SLOT) begin
              en_d[i] = ~en_q[i];
            end else begin
              slot_d[i] = work_q;
              en_d[i]   = 1'b1;
            end
          end
        end
      end
    end
  end

  // Edit-side registers
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      for (int i = 0; i < N_ALARM; i++) slot_q[i] <= '0;
      en_q    <= '0;
      work_q  <= '0;
      sel_q   <= '0;
      field_q <= FIELD_SLOT;
    end else begin
      slot_q  <= slot_d;
      en_q    <= en_d;
      work_q  <= work_d;
      sel_q   <= sel_d;
      field_q <= field_d;
    end
  end

  // Ring state machine: dismiss beats snooze beats timeout; slot hits beat snooze expiry
  always_comb begin
    state_d   = state_q;
    ring_id_d = ring_id_q;
    snooze_d  = snooze_q;
    tmo_d     = tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (SEC_TICK && any_hit) begin
          state_d   = ST_RING;
          ring_id_d = hit_id;
          tmo_d     = '0;
        end
      end
      ST_RING: begin
        if (OK && in_clock) begin
          state_d = ST_IDLE;
        end else if (DOWN && !in_edit) begin
          state_d  = ST_SNOOZE;
          snooze_d = add_minutes(now_tod, SNOOZE_LEN);
        end else if (SEC_TICK) begin
          tmo_d = tmo_q + 8'd1;
          if (tmo_q + 8'd1 == TIMEOUT_CNT) state_d = ST_IDLE;
        end
      end
      ST_SNOOZE: begin
        if (OK && in_clock) begin
          state_d = ST_IDLE;
        end else if (SEC_TICK && any_hit) begin
          state_d   = ST_RING;
          ring_id_d = hit_id;
          tmo_d     = '0;
        end else if (SEC_TICK && (now_tod == snooze_q)) begin
          state_d = ST_RING;
          tmo_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Ring-side registers
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q   <= ST_IDLE;
      ring_id_q <= '0;
      snooze_q  <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      ring_id_q <= ring_id_d;
      snooze_q  <= snooze_d;
      tmo_q     <= tmo_d;
    end
  end

  tone_gen #(
    .TONE_DIV (TONE_DIV)
  ) u_tone (
    .CLK    (CLK),
    .RESETN (RESETN),
    .EN     (state_q == ST_RING),
    .PIEZO  (PIEZO)
  );

  assign ARM_HOUR  = in_edit ? work_q.hour : cur_slot.hour;
  assign ARM_MIN   = in_edit ? work_q.min  : cur_slot.min;
  assign ARM_SEC   = in_edit ? work_q.sec  : cur_slot.sec;
  assign SEL_ALARM = sel_q;
  assign FIELD_SEL = field_q;
  assign ARM_EN    = en_q;
  assign RINGING   = (state_q == ST_RING);
  assign RING_ID   = ring_id_q;

endmodule
`default_nettype wire

// File: tb/tb_alarm_bank.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_alarm_bank
//  Purpose  : Self-checking bench for alarm_bank against a time-in-seconds model
//  Revision : 1.0  initial release
// ============================================================================
module tb_alarm_bank;

  localparam int N     = 4;
  localparam int EDIT  = 2;
  localparam int CLKST = 0;
  localparam int TD    = 4;
  localparam int SNZ   = 5;
  localparam int RT    = 3;
  localparam int DAY   = 86400;

  logic         CLK = 1'b0;
  logic         RESETN;
  logic [2:0]   STATE;
  logic         UP, DOWN, SHIFT, OK, SEC_TICK;
  logic [6:0]   HOUR, MIN, SEC;
  logic [6:0]   ARM_HOUR, ARM_MIN, ARM_SEC;
  logic [2:0]   SEL_ALARM;
  logic [1:0]   FIELD_SEL;
  logic [N-1:0] ARM_EN;
  logic         RINGING;
  logic [2:0]   RING_ID;
  logic         PIEZO;

  alarm_bank #(
    .N_ALARM(N), .EDIT_STATE(EDIT), .CLOCK_STATE(CLKST),
    .TONE_DIV(TD), .SNOOZE_MIN(SNZ), .RING_TIMEOUT(RT)
  ) dut (
    .CLK(CLK), .RESETN(RESETN), .STATE(STATE), .UP(UP), .DOWN(DOWN),
    .SHIFT(SHIFT), .OK(OK), .SEC_TICK(SEC_TICK), .HOUR(HOUR), .MIN(MIN), .SEC(SEC),
    .ARM_HOUR(ARM_HOUR), .ARM_MIN(ARM_MIN), .ARM_SEC(ARM_SEC),
    .SEL_ALARM(SEL_ALARM), .FIELD_SEL(FIELD_SEL), .ARM_EN(ARM_EN),
    .RINGING(RINGING), .RING_ID(RING_ID), .PIEZO(PIEZO)
  );

  always #5 CLK = ~CLK;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 0;
  int tod         = 0;

  // Model: times in plain integers, mode 0 idle / 1 ringing / 2 snoozing
  int m_h [N];
  int m_m [N];
  int m_s [N];
  bit m_en[N];
  int m_sel, m_field, w_h, w_m, w_s;
  int m_mode, m_id, m_snz, m_ticks, m_age;

  function automatic int slot_secs(input int i);
    return m_h[i] * 3600 + m_m[i] * 60 + m_s[i];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_h[i] = 0; m_m[i] = 0; m_s[i] = 0; m_en[i] = 0;
    end
    m_sel = 0; m_field = 0; w_h = 0; w_m = 0; w_s = 0;
    m_mode = 0; m_id = 0; m_snz = 0; m_ticks = 0; m_age = 0;
  endtask

  task automatic enter_ring(input int id);
    m_mode = 1; m_id = id; m_ticks = 0; m_age = 0;
  endtask

  task automatic model_step();
    int hit, d, of, os, oh, om, osc;
    bit clk_ok;
    if (m_mode == 1) m_age++;
    hit = -1;
    if (SEC_TICK)
      for (int i = N - 1; i >= 0; i--)
        if (m_en[i] && slot_secs(i) == tod) hit = i;
    clk_ok = OK && (STATE == CLKST);
    case (m_mode)
      0: if (hit >= 0) enter_ring(hit);
      1: begin
        if (clk_ok) m_mode = 0;
        else if (DOWN && STATE != EDIT) begin
          m_mode = 2;
          m_snz  = (tod + SNZ * 60) % DAY;
        end else if (SEC_TICK) begin
          m_ticks++;
          if (m_ticks == RT) m_mode = 0;
        end
      end
      default: begin
        if (clk_ok) m_mode = 0;
        else if (hit >= 0) enter_ring(hit);
        else if (SEC_TICK && tod == m_snz) enter_ring(m_id);
      end
    endcase
    if (STATE == EDIT) begin
      of = m_field; os = m_sel; oh = w_h; om = w_m; osc = w_s;
      if (SHIFT) m_field = (of + 1) % 4;
      if (UP != DOWN) begin
        d = UP ? 1 : -1;
        if (of == 0) begin
          m_sel = (os + d + N) % N;
          w_h = m_h[m_sel]; w_m = m_m[m_sel]; w_s = m_s[m_sel];
        end else if (of == 1) w_h = (w_h + d + 24) % 24;
        else if (of == 2)     w_m = (w_m + d + 60) % 60;
        else                  w_s = (w_s + d + 60) % 60;
      end
      if (OK) begin
        if (of == 0) m_en[os] = !m_en[os];
        else begin
          m_h[os] = oh; m_m[os] = om; m_s[os] = osc; m_en[os] = 1;
        end
      end
    end else begin
      w_h = m_h[m_sel]; w_m = m_m[m_sel]; w_s = m_s[m_sel];
    end
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge CLK) begin
    int eh, em, es;
    logic [N-1:0] een;
    bit epz;
    if (chk_en) begin
      if (STATE == EDIT) begin eh = w_h; em = w_m; es = w_s; end
      else begin eh = m_h[m_sel]; em = m_m[m_sel]; es = m_s[m_sel]; end
      for (int i = 0; i < N; i++) een[i] = m_en[i];
      epz = (m_mode == 1) && (((m_age / TD) % 2) == 1);
      vectors++;
      if (ARM_HOUR != eh || ARM_MIN != em || ARM_SEC != es || SEL_ALARM != m_sel ||
          FIELD_SEL != m_field || ARM_EN != een || RINGING != (m_mode == 1) ||
          RING_ID != m_id || PIEZO != epz) begin
        miscompares++;
        $display("FAIL outputs t=%0t got %0d:%0d:%0d sel%0d fld%0d en%b ring%b id%0d pz%b, exp %0d:%0d:%0d sel%0d fld%0d en%b ring%b id%0d pz%b",
                 $time, ARM_HOUR, ARM_MIN, ARM_SEC, SEL_ALARM, FIELD_SEL, ARM_EN, RINGING, RING_ID, PIEZO,
                 eh, em, es, m_sel, m_field, een, (m_mode == 1), m_id, epz);
      end
    end
  end

  task automatic check_lit(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s got %0d expected %0d t=%0t", name, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model
  task automatic cyc(input logic [2:0] st, input logic up, input logic dn,
                     input logic sh, input logic ok, input logic tk);
    if (tk) tod = (tod + 1) % DAY;
    STATE = st; UP = up; DOWN = dn; SHIFT = sh; OK = ok; SEC_TICK = tk;
    HOUR = 7'(tod / 3600); MIN = 7'((tod / 60) % 60); SEC = 7'(tod % 60);
    @(posedge CLK);
    if (RESETN) model_step(); else model_reset();
    #1;
  endtask

  task automatic idle(input logic [2:0] st, input int n);
    for (int i = 0; i < n; i++) cyc(st, 0, 0, 0, 0, 0);
  endtask

  task automatic set_time(input int h, input int m, input int s);
    tod = h * 3600 + m * 60 + s;
  endtask

  task automatic press(input logic [2:0] st, input int which, input int n);
    for (int i = 0; i < n; i++)
      cyc(st, which == 0, which == 1, which == 2, which == 3, 0);
  endtask

  localparam int P_UP = 0, P_DN = 1, P_SH = 2, P_OK = 3;

  initial begin
    RESETN = 0; STATE = 0; UP = 0; DOWN = 0; SHIFT = 0; OK = 0; SEC_TICK = 0;
    HOUR = 0; MIN = 0; SEC = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1 RESETN = 1;
    chk_en = 1;
    check_lit("reset_ringing", RINGING, 0);
    check_lit("reset_en", ARM_EN, 0);
    check_lit("reset_sel", SEL_ALARM, 0);
    check_lit("reset_piezo", PIEZO, 0);

    // Edit slot 0 to 07:59:00 and commit
    idle(3'd2, 1);
    press(3'd2, P_SH, 1); press(3'd2, P_UP, 7);
    press(3'd2, P_SH, 1); press(3'd2, P_DN, 1);
    press(3'd2, P_OK, 1);
    idle(3'd0, 2);
    check_lit("edit_hour", ARM_HOUR, 7);
    check_lit("edit_min", ARM_MIN, 59);
    check_lit("edit_sec", ARM_SEC, 0);
    check_lit("edit_en0", ARM_EN[0], 1);

    // Ring, tone and dismiss
    set_time(7, 58, 59); cyc(3'd0, 0, 0, 0, 0, 1);
    check_lit("ring_on", RINGING, 1);
    check_lit("ring_id0", RING_ID, 0);
    idle(3'd0, 3);
    check_lit("tone_low", PIEZO, 0);
    idle(3'd0, 1);
    check_lit("tone_high", PIEZO, 1);
    press(3'd0, P_OK, 1);
    check_lit("dismiss_ring", RINGING, 0);
    check_lit("dismiss_piezo", PIEZO, 0);

    // Slot 1 at 23:58:00, snooze across midnight
    press(3'd2, P_SH, 2); press(3'd2, P_UP, 1);
    press(3'd2, P_SH, 1); press(3'd2, P_DN, 1);
    press(3'd2, P_SH, 1); press(3'd2, P_DN, 2);
    press(3'd2, P_OK, 1);
    idle(3'd0, 1);
    set_time(23, 57, 59); cyc(3'd0, 0, 0, 0, 0, 1);
    check_lit("snz_ring_id1", RING_ID, 1);
    press(3'd0, P_DN, 1);
    check_lit("snz_quiet", RINGING, 0);
    idle(3'd0, 2);
    set_time(0, 2, 59); cyc(3'd0, 0, 0, 0, 0, 1);
    check_lit("snz_reringing", RINGING, 1);
    check_lit("snz_reid", RING_ID, 1);
    press(3'd0, P_OK, 1);

    // Slots 2 and 3 both at 12:00:00
    press(3'd2, P_SH, 2); press(3'd2, P_UP, 1);
    press(3'd2, P_SH, 1); press(3'd2, P_UP, 12); press(3'd2, P_OK, 1);
    press(3'd2, P_SH, 3); press(3'd2, P_UP, 1);
    press(3'd2, P_SH, 1); press(3'd2, P_UP, 12); press(3'd2, P_OK, 1);
    idle(3'd0, 1);
    set_time(11, 59, 59); cyc(3'd0, 0, 0, 0, 0, 1);
    check_lit("prio_id2", RING_ID, 2);
    set_time(11, 59, 59); cyc(3'd0, 0, 0, 0, 0, 1);
    check_lit("prio_hold_ring", RINGING, 1);
    check_lit("prio_hold_id", RING_ID, 2);
    press(3'd0, P_OK, 1);

    // Timeout after three ticks
    set_time(7, 58, 59); cyc(3'd0, 0, 0, 0, 0, 1);
    idle(3'd0, 1);
    cyc(3'd0, 0, 0, 0, 0, 1); idle(3'd0, 1);
    cyc(3'd0, 0, 0, 0, 0, 1);
    check_lit("tmo_still", RINGING, 1);
    idle(3'd0, 1);
    cyc(3'd0, 0, 0, 0, 0, 1);
    check_lit("tmo_off", RINGING, 0);
    check_lit("tmo_en_kept", ARM_EN[0], 1);

    // Asynchronous reset in the middle of a ring
    set_time(7, 58, 59); cyc(3'd0, 0, 0, 0, 0, 1);
    idle(3'd0, 5);
    #2 RESETN = 0;
    model_reset();
    #1;
    check_lit("arst_ringing", RINGING, 0);
    check_lit("arst_piezo", PIEZO, 0);
    check_lit("arst_en", ARM_EN, 0);
    @(posedge CLK); #1;
    idle(3'd0, 1);
    RESETN = 1;

    // Randomised traffic
    begin
      int st;
      st = 0;
      for (int c = 0; c < 4000; c++) begin
        int r, k;
        if ($urandom_range(0, 19) == 0) begin
          r  = $urandom_range(0, 5);
          st = (r < 2) ? 0 : (r < 4) ? 2 : (r == 4) ? 1 : 5;
        end
        if ($urandom_range(0, 29) == 0) begin
          if (m_mode == 2 && $urandom_range(0, 1) == 1) tod = (m_snz + DAY - 1) % DAY;
          else begin
            k   = $urandom_range(0, N - 1);
            tod = (slot_secs(k) + DAY - 1) % DAY;
          end
        end
        r = $urandom_range(0, 15);
        cyc(3'(st), r == 0 || r == 4, r == 1 || r == 4, r == 2, r == 3,
            $urandom_range(0, 3) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
